// File: rtl/pkt_stream_chk.sv
// AXI-Stream frame checker: per-frame length, runt/giant, byte-pattern and FCS statistics.
// Optional macro PKT_CHK_BACKPRESSURE_EN drives tready from an 8-bit LFSR.
module pkt_stream_chk #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32,
    parameter int MIN_LEN = 46,
    parameter int MAX_LEN = 1500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic                bad_fcs,
    input  logic                clr_stats,
    output logic [CNT_W-1:0]    frames_rcvd,
    output logic [CNT_W-1:0]    bad_count,
    output logic [CNT_W-1:0]    byte_count,
    output logic [CNT_W-1:0]    runt_count,
    output logic [CNT_W-1:0]    giant_count,
    output logic [CNT_W-1:0]    pat_err_count,
    output logic [15:0]         last_len,
    output logic                frame_done,
    output logic                in_frame
);

    localparam int          KW      = DATA_W / 8;
    localparam int          PW      = $clog2(KW + 1);
    localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
    localparam logic [15:0] LEN_CAP = 16'(MAX_LEN + 1);

    typedef enum logic {IDLE, BODY} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_len;
    logic [7:0]      r_exp;
    logic            r_err;

    logic            w_acc;
    logic            w_fin;
    logic [PW-1:0]   w_pc;
    logic [15:0]     w_base_len;
    logic [16:0]     w_len_sum;
    logic [15:0]     w_len_nxt;
    logic [7:0]      w_seed;
    logic [7:0]      w_exp_nxt;
    logic            w_beat_err;
    logic            w_err_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic en);
        if (en && (a != {CNT_W{1'b1}}))
            return a + {{(CNT_W-1){1'b0}}, 1'b1};
        return a;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

`ifdef PKT_CHK_BACKPRESSURE_EN
    logic [7:0] r_lfsr;
    logic       w_fb;

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_lfsr <= 8'hA5;
        else
            r_lfsr <= {r_lfsr[6:0], w_fb};
    end

    assign s_axis_tready = r_lfsr[0] & ~rst;
`else
    assign s_axis_tready = 1'b1;
`endif

    assign w_acc = s_axis_tvalid & s_axis_tready;
    assign w_fin = w_acc & s_axis_tlast;

    // A beat seen in IDLE always opens a new frame, so its offset starts at zero.
    assign w_base_len = (r_state == BODY) ? r_len : 16'd0;
    assign w_len_sum  = {1'b0, w_base_len} + 17'(w_pc);
    assign w_len_nxt  = (w_len_sum > {1'b0, LEN_CAP}) ? LEN_CAP : w_len_sum[15:0];

    // Until the first byte arrives, the current beat's byte 0 defines the pattern.
    assign w_seed    = (w_base_len == 16'd0) ? s_axis_tdata[7:0] : r_exp;
    assign w_exp_nxt = w_seed + 8'(w_pc);
    assign w_err_nxt = ((r_state == BODY) & r_err) | w_beat_err;

    always_comb begin
        w_pc       = '0;
        w_beat_err = 1'b0;
        for (int i = 0; i < KW; i++) begin
            w_pc = w_pc + PW'(s_axis_tkeep[i]);
            if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != (w_seed + 8'(i))))
                w_beat_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_frame    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_acc && !s_axis_tlast)
                    w_state_nxt = BODY;
            end
            BODY: begin
                in_frame = 1'b1;
                if (w_fin)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= '0;
            r_exp <= '0;
            r_err <= 1'b0;
        end else if (w_acc) begin
            r_len <= w_len_nxt;
            r_exp <= w_exp_nxt;
            r_err <= w_err_nxt;
        end
    end

    // Frame results land on the edge that accepts tlast; clr_stats only masks counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done    <= 1'b0;
            last_len      <= '0;
            frames_rcvd   <= '0;
            bad_count     <= '0;
            byte_count    <= '0;
            runt_count    <= '0;
            giant_count   <= '0;
            pat_err_count <= '0;
        end else begin
            frame_done <= w_fin;
            if (w_fin)
                last_len <= w_len_nxt;
            if (clr_stats) begin
                frames_rcvd   <= '0;
                bad_count     <= '0;
                byte_count    <= '0;
                runt_count    <= '0;
                giant_count   <= '0;
                pat_err_count <= '0;
            end else begin
                frames_rcvd   <= sat_inc(frames_rcvd, w_fin);
                bad_count     <= sat_inc(bad_count, bad_fcs);
                byte_count    <= sat_add(byte_count, w_acc ? CNT_W'(w_pc) : '0);
                runt_count    <= sat_inc(runt_count, w_fin && (w_len_nxt < MIN_L));
                giant_count   <= sat_inc(giant_count, w_fin && (w_len_nxt > MAX_L));
                pat_err_count <= sat_inc(pat_err_count, w_fin && w_err_nxt);
            end
        end
    end

endmodule

// File: tb/tb_pkt_stream_chk.sv
// Randomized self-checking bench for pkt_stream_chk against a frame-level reference model.
module tb_pkt_stream_chk;

    localparam int     DATA_W  = 32;
    localparam int     CNT_W   = 12;
    localparam int     MIN_LEN = 46;
    localparam int     MAX_LEN = 1500;
    localparam longint CMAX    = (longint'(1) << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic [3:0]        s_axis_tkeep = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              s_axis_tlast = 1'b0;
    logic              bad_fcs = 1'b0;
    logic              clr_stats = 1'b0;
    logic [CNT_W-1:0]  frames_rcvd, bad_count, byte_count, runt_count, giant_count, pat_err_count;
    logic [15:0]       last_len;
    logic              frame_done, in_frame;

    always #5 clk = ~clk;

    pkt_stream_chk #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .bad_fcs(bad_fcs), .clr_stats(clr_stats),
        .frames_rcvd(frames_rcvd), .bad_count(bad_count), .byte_count(byte_count),
        .runt_count(runt_count), .giant_count(giant_count), .pat_err_count(pat_err_count),
        .last_len(last_len), .frame_done(frame_done), .in_frame(in_frame)
    );

    int n_chk = 0;
    int n_bad = 0;

    longint m_frames, m_bad, m_bytes, m_runt, m_giant, m_pat, m_last;
    logic [7:0] fq[$];

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_clear();
        m_frames = 0; m_bad = 0; m_bytes = 0; m_runt = 0; m_giant = 0; m_pat = 0;
    endtask

    task automatic check_stats(input string tag);
        check_val({tag, ".frames"},   longint'(frames_rcvd),   m_frames);
        check_val({tag, ".bad"},      longint'(bad_count),     m_bad);
        check_val({tag, ".bytes"},    longint'(byte_count),    m_bytes);
        check_val({tag, ".runt"},     longint'(runt_count),    m_runt);
        check_val({tag, ".giant"},    longint'(giant_count),   m_giant);
        check_val({tag, ".pat_err"},  longint'(pat_err_count), m_pat);
        check_val({tag, ".last_len"}, longint'(last_len),      m_last);
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic fcs, input logic clr);
        int w;
        w = 0;
        @(negedge clk);
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        bad_fcs = fcs; clr_stats = clr;
        while (!s_axis_tready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check_val("tready_wait", w, 0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; bad_fcs = 1'b0; clr_stats = 1'b0;
        if (fcs) m_bad = sat(m_bad + w + 1);
    endtask

    task automatic make_frame(input int n, input logic [7:0] b0);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(8'(b0 + 8'(i)));
    endtask

    task automatic send_frame(input string tag, input bit fixed4, input bit clr_last, input bit fcs_rand);
        int n, pos, nb;
        bit last, err;
        n = fq.size(); pos = 0; nb = 0; last = 0;
        while (!last) begin
            int c;
            logic [31:0] d;
            logic [3:0] k;
            logic fcs;
            if (fixed4) c = 4;
            else c = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(4, 1));
            if (pos + c >= n) begin c = n - pos; last = 1; end
            d = $urandom;
            for (int i = 0; i < c; i++) d[8*i +: 8] = fq[pos + i];
            k = 4'((1 << c) - 1);
            fcs = fcs_rand ? ($urandom_range(3, 0) == 0) : 1'b0;
            drive_beat(d, k, last, fcs, clr_last && last);
            pos += c;
            nb++;
            if (nb == 1 && !last) begin
                @(negedge clk);
                check_val({tag, ".in_frame"}, longint'(in_frame), 1);
            end
        end
        err = 0;
        for (int i = 1; i < n; i++) if (fq[i] != 8'(fq[0] + 8'(i))) err = 1;
        m_frames = sat(m_frames + 1);
        m_bytes  = sat(m_bytes + n);
        m_last   = (n > MAX_LEN) ? MAX_LEN + 1 : n;
        if (n < MIN_LEN) m_runt  = sat(m_runt + 1);
        if (n > MAX_LEN) m_giant = sat(m_giant + 1);
        if (err)         m_pat   = sat(m_pat + 1);
        if (clr_last) model_clear();
        @(negedge clk);
        check_val({tag, ".done"}, longint'(frame_done), 1);
        check_val({tag, ".idle"}, longint'(in_frame), 0);
        check_stats(tag);
        @(negedge clk);
        check_val({tag, ".done_off"}, longint'(frame_done), 0);
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, ".in_frame"}, longint'(in_frame), 0);
        check_val({tag, ".done"},     longint'(frame_done), 0);
`ifdef PKT_CHK_BACKPRESSURE_EN
        check_val({tag, ".tready"},   longint'(s_axis_tready), 0);
`else
        check_val({tag, ".tready"},   longint'(s_axis_tready), 1);
`endif
        check_stats(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        m_last = 0;

        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        reset_checks("por");
        rst = 1'b0;

`ifdef PKT_CHK_BACKPRESSURE_EN
        begin
            logic [7:0] m;
            m = 8'hA5;
            for (int i = 0; i < 8; i++) begin
                check_val($sformatf("lfsr%0d", i), longint'(s_axis_tready), longint'(m[0]));
                m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
                @(negedge clk);
            end
        end
`endif

        // 64-byte good frame
        make_frame(64, 8'h00);
        send_frame("f64", 1'b1, 1'b0, 1'b0);

        // 10-byte runt, last beat keep 0011
        make_frame(10, 8'h37);
        send_frame("runt10", 1'b1, 1'b0, 1'b0);

        // 1600-byte giant, length saturates
        make_frame(1600, 8'hC0);
        send_frame("giant", 1'b1, 1'b0, 1'b0);

        // byte 20 corrupted
        make_frame(64, 8'h00);
        fq[20] = 8'hFF;
        send_frame("corrupt", 1'b1, 1'b0, 1'b0);

        // three isolated bad_fcs pulses
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bad_fcs = 1'b1;
            @(negedge clk); bad_fcs = 1'b0;
            m_bad = sat(m_bad + 1);
        end
        @(negedge clk);
        check_val("fcs3.bad", longint'(bad_count), m_bad);

        // clr_stats coincident with tlast
        make_frame(20, 8'h10);
        send_frame("clr_last", 1'b0, 1'b1, 1'b0);

        // reset in the middle of a frame
        make_frame(8, 8'h55);
        drive_beat({fq[3], fq[2], fq[1], fq[0]}, 4'hF, 1'b0, 1'b0, 1'b0);
        drive_beat({fq[7], fq[6], fq[5], fq[4]}, 4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("mid.in_frame", longint'(in_frame), 1);
        rst = 1'b1;
        model_clear();
        m_last = 0;
        @(negedge clk);
        reset_checks("mid_rst");
        rst = 1'b0;
        make_frame(64, 8'hE0);
        send_frame("after_rst", 1'b1, 1'b0, 1'b0);

        // zero-byte frame: single tlast beat with tkeep 0
        fq.delete();
        send_frame("empty", 1'b0, 1'b0, 1'b0);

        // randomized frames around the length boundaries
        for (int f = 0; f < 24; f++) begin
            int sel, n;
            sel = int'($urandom_range(9, 0));
            if (sel < 5)      n = int'($urandom_range(120, 0));
            else if (sel < 7) n = int'($urandom_range(MIN_LEN + 2, MIN_LEN - 2));
            else if (sel < 9) n = int'($urandom_range(MAX_LEN + 3, MAX_LEN - 3));
            else              n = int'($urandom_range(1700, MAX_LEN + 1));
            make_frame(n, 8'($urandom));
            if (n > 0 && $urandom_range(9, 0) < 3) begin
                int idx;
                idx = int'($urandom_range(n - 1, 0));
                fq[idx] = fq[idx] ^ 8'($urandom_range(255, 1));
            end
            send_frame($sformatf("rnd%0d", f), 1'b0, 1'b0, 1'b1);
        end

        // byte_count must be pinned at all-ones, then a standalone clear
        check_val("sat.bytes", longint'(byte_count), CMAX);
        @(negedge clk); clr_stats = 1'b1;
        @(negedge clk); clr_stats = 1'b0;
        model_clear();
        check_stats("clr");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pkt_stream_chk.md
PKT_STREAM_CHK -- requirements
Module: pkt_stream_chk

Interface
REQ-001 SHALL have parameter DATA_W, default 32, tdata width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter CNT_W, default 32, width of every statistics counter.
REQ-003 SHALL have parameter MIN_LEN, default 46, smallest legal payload length in bytes.
REQ-004 SHALL have parameter MAX_LEN, default 1500, largest legal payload length in bytes.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-006 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: s_axis_tdata  in  DATA_W  payload, byte 0 in bits [7:0].
REQ-008 SHALL have ports: s_axis_tkeep  in  DATA_W/8  byte enables, low-aligned and contiguous.
REQ-009 SHALL have ports: s_axis_tvalid  in  1;  s_axis_tready  out  1;  s_axis_tlast  in  1.
REQ-010 SHALL have ports: bad_fcs  in  1  single-cycle pulse from the RX FCS checker.
REQ-011 SHALL have ports: clr_stats  in  1  synchronous clear of all counters.
REQ-012 SHALL have outputs of width CNT_W: frames_rcvd, bad_count, byte_count, runt_count, giant_count, pat_err_count.
REQ-013 SHALL have outputs: last_len  out  16  byte length of the most recently completed frame; frame_done  out  1  one-cycle pulse; in_frame  out  1.

Function
REQ-014 A beat SHALL be accepted only when s_axis_tvalid and s_axis_tready are both high.
REQ-015 The FSM SHALL have two states, IDLE and BODY. IDLE goes to BODY on an accepted beat with tlast low. BODY returns to IDLE on an accepted beat with tlast high. A single-beat frame with tlast high SHALL stay in IDLE and complete the frame.
REQ-016 in_frame SHALL be high exactly while the state is BODY.
REQ-017 The frame length accumulator SHALL add popcount(tkeep) per accepted beat, saturating at MAX_LEN+1.
REQ-018 byte_count SHALL add popcount(tkeep) per accepted beat.
REQ-019 Pattern check: expected byte k of a frame = (byte 0 + k) mod 256. Any mismatch in an enabled byte SHALL set a per-frame error flag.
REQ-020 On the accepted tlast beat, the block SHALL, one cycle later:
  - increment frames_rcvd;
  - update last_len;
  - increment runt_count if length < MIN_LEN;
  - increment giant_count if length > MAX_LEN;
  - increment pat_err_count once if the flag is set (the tlast beat's own bytes included);
  - pulse frame_done for 1 cycle.
REQ-021 bad_count SHALL increment by one per cycle with bad_fcs high, independent of frame state.
REQ-022 All counters SHALL saturate at all-ones and never wrap.
REQ-023 clr_stats SHALL zero all CNT_W counters on the next edge and take priority over a same-cycle increment. last_len, the FSM and the per-frame accumulators SHALL be unaffected.
REQ-024 A tkeep of zero on an accepted beat SHALL add 0 bytes but still honour tlast.
REQ-025 With the feature in REQ-029 disabled, s_axis_tready SHALL be constant 1.

Reset
REQ-026 While rst is high, the block SHALL hold: state IDLE, all counters 0, last_len 0, frame_done 0, in_frame 0, accumulators and error flag 0.
REQ-027 rst asserted mid-frame SHALL discard the partial frame. The first accepted beat after release SHALL start a new frame.
REQ-028 s_axis_tready SHALL be 0 during reset when the macro is defined.

Configuration
REQ-029 Macro PKT_CHK_BACKPRESSURE_EN:
  - Defined: an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), reset seed 8'hA5, SHALL advance every cycle, with s_axis_tready = lfsr[0].
  - Undefined: no LFSR, and tready per REQ-025.

Verification
REQ-030 One frame of 64 bytes (DATA_W=32, bytes 0x00..0x3F, tkeep all ones) -> frames_rcvd=1, last_len=64, byte_count=64, runt/giant/pat_err=0, frame_done one pulse.
REQ-031 Frame of 10 bytes (last beat tkeep=4'b0011) -> runt_count=1, last_len=10, byte_count=10.
REQ-032 Frame of 1600 bytes -> giant_count=1, last_len=1501.
REQ-033 64-byte frame with byte 20 corrupted to 0xFF -> pat_err_count=1, frames_rcvd=1. Three bad_fcs pulses -> bad_count=3.
REQ-034 clr_stats asserted in the same cycle as an increment from a tlast beat -> all counters 0 afterwards; last_len still updated.
REQ-035 rst asserted after 8 bytes of a frame, then a full 64-byte frame -> frames_rcvd=1, last_len=64. With PKT_CHK_BACKPRESSURE_EN, the first 8 tready values after reset equal the LFSR sequence from seed 0xA5.
